// File: rtl/uc_pkg.sv
// Shared types and constants for the multicycle control unit.
// UC_ILLEGAL_TRAP_EN adds the HALT state used to trap unknown opcodes.
package uc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_R  = 4'b0000;
  localparam logic [3:0] ALU_I  = 4'b0001;
  localparam logic [3:0] ALU_LS = 4'b0010;
  localparam logic [3:0] ALU_BR = 4'b0011;
  localparam logic [3:0] ALU_U  = 4'b0100;
  localparam logic [3:0] ALU_J  = 4'b0101;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef UC_ILLEGAL_TRAP_EN
    , ST_HALT
`endif
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_U, CL_ILLEGAL
  } iclass_e;

  // Unknown opcodes fall back to the R command; they never write anything.
  function automatic logic [3:0] alu_cmd_of(iclass_e cls);
    case (cls)
      CL_I:              return ALU_I;
      CL_LOAD, CL_STORE: return ALU_LS;
      CL_BRANCH:         return ALU_BR;
      CL_U:              return ALU_U;
      CL_JAL, CL_JALR:   return ALU_J;
      default:           return ALU_R;
    endcase
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode -> instruction class decoder.
module uc_decode
  import uc_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_e    cls
);

  always_comb begin
    cls = CL_ILLEGAL;
    case (opcode)
      OP_R:             cls = CL_R;
      OP_I:             cls = CL_I;
      OP_LOAD:          cls = CL_LOAD;
      OP_STORE:         cls = CL_STORE;
      OP_BRANCH:        cls = CL_BRANCH;
      OP_JAL:           cls = CL_JAL;
      OP_JALR:          cls = CL_JALR;
      OP_LUI, OP_AUIPC: cls = CL_U;
      default:          cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer plus retired-instruction counter.
// Define UC_ILLEGAL_TRAP_EN to halt on unknown opcodes instead of treating them as NOPs.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [3:0]       alu_flags,
  input  logic             i_mem_ack,
  input  logic             d_mem_ack,
  output logic             i_mem_req,
  output logic             d_mem_req,
  output logic             d_mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [3:0]       alu_cmd,
  output logic             alu_src,
  output logic             pc_src,
  output logic             rf_src,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  iclass_e          cls;
  logic             unused_flags;

  assign unused_flags = ^alu_flags[3:1];

  uc_decode u_dec (.opcode(opcode), .cls(cls));

  always_comb begin
    state_d   = state_q;
    i_mem_req = 1'b0;
    d_mem_req = 1'b0;
    d_mem_we  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    alu_cmd   = ALU_R;
    alu_src   = 1'b0;
    pc_src    = 1'b0;
    rf_src    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        i_mem_req = 1'b1;
        if (i_mem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
`ifdef UC_ILLEGAL_TRAP_EN
        state_d = (cls == CL_ILLEGAL) ? ST_HALT : ST_EXEC;
`else
        state_d = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        alu_cmd = alu_cmd_of(cls);
        alu_src = (cls == CL_I) || (cls == CL_LOAD) || (cls == CL_STORE) || (cls == CL_JALR);
        if (cls == CL_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = alu_flags[0];
          state_d = ST_FETCH;
        end else if ((cls == CL_LOAD) || (cls == CL_STORE)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        d_mem_req = 1'b1;
        d_mem_we  = (cls == CL_STORE);
        if (d_mem_ack) begin
          if (cls == CL_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = (cls != CL_ILLEGAL);
        pc_we   = 1'b1;
        rf_src  = (cls == CL_LOAD);
        pc_src  = (cls == CL_JAL) || (cls == CL_JALR);
        state_d = ST_FETCH;
      end
`ifdef UC_ILLEGAL_TRAP_EN
      ST_HALT: illegal = 1'b1;
`endif
      default: state_d = ST_FETCH;
    endcase

    // The reset cycle must not leak strobes from whatever state we were in.
    if (rst) begin
      i_mem_req = 1'b0;
      d_mem_req = 1'b0;
      d_mem_we  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      illegal   = 1'b0;
    end

    instret_d = instret_q + (pc_we ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomized self-checking bench: per-instruction transaction model of the control unit.
module tb_uc_multiciclo;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic [3:0]       alu_flags;
  logic             i_mem_ack, d_mem_ack;
  logic             i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, rf_we;
  logic [3:0]       alu_cmd;
  logic             alu_src, pc_src, rf_src, illegal;
  logic [CNT_W-1:0] instret;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  uc_multiciclo #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_flags(alu_flags),
    .i_mem_ack(i_mem_ack), .d_mem_ack(d_mem_ack),
    .i_mem_req(i_mem_req), .d_mem_req(d_mem_req), .d_mem_we(d_mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .alu_cmd(alu_cmd),
    .alu_src(alu_src), .pc_src(pc_src), .rf_src(rf_src),
    .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction classes of the reference model.
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_U = 7, C_ILL = 8;

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111, 7'b0010111: return C_U;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input int c);
    case (c)
      C_R:          return 4'b0000;
      C_I:          return 4'b0001;
      C_LD, C_ST:   return 4'b0010;
      C_BR:         return 4'b0011;
      C_U:          return 4'b0100;
      default:      return 4'b0101;
    endcase
  endfunction

  function automatic int strobes();
    return int'(i_mem_req) + int'(d_mem_req) + int'(d_mem_we) + int'(ir_we) + int'(pc_we) + int'(rf_we);
  endfunction

  // Runs one instruction: fetch ack after iw wait cycles, data ack after dw wait cycles.
  // abort asserts rst in the second MEM cycle instead of acking.
  task automatic run_instr(input logic [6:0] opc, input int iw, input int dw, input bit flag, input bit abort);
    int  c, cyc, n_ireq, n_irwe, n_dreq, n_dwe, n_dwe_bad, n_rf, n_pc, n_ill, after_ir;
    int  e_dreq, e_dwe, e_rf, e_cyc;
    bit  seen_ir, done, aborted, ls;
    logic pcs, rfs, asrc;
    logic [3:0] acmd;
    c = cls_of(opc);
    cyc = 0; n_ireq = 0; n_irwe = 0; n_dreq = 0; n_dwe = 0; n_dwe_bad = 0;
    n_rf = 0; n_pc = 0; n_ill = 0; after_ir = 0;
    seen_ir = 0; done = 0; aborted = 0;
    pcs = 0; rfs = 0; asrc = 0; acmd = 4'hf;
    while (!done && cyc < 60) begin
      @(negedge clk);
      opcode    = seen_ir ? opc : 7'($urandom);
      alu_flags = {3'($urandom), flag};
      #1;
      i_mem_ack = i_mem_req ? (n_ireq == iw) : 1'($urandom);
      d_mem_ack = d_mem_req ? (n_dreq == dw) : 1'($urandom);
      if (abort && d_mem_req && n_dreq == 1) begin
        rst = 1'b1; d_mem_ack = 1'b0; aborted = 1; done = 1;
        #1;
        chk("rst_cycle_strobes", strobes(), 0);
      end
      #1;
      if (i_mem_req) n_ireq++;
      if (ir_we) n_irwe++;
      if (d_mem_req) n_dreq++;
      if (d_mem_we) n_dwe++;
      if (d_mem_we && !d_mem_req) n_dwe_bad++;
      if (rf_we) begin n_rf++; rfs = rf_src; end
      if (illegal) n_ill++;
      if (seen_ir) after_ir++;
      if (after_ir == 2) begin acmd = alu_cmd; asrc = alu_src; end
      if (ir_we) seen_ir = 1;
      if (pc_we) begin n_pc++; pcs = pc_src; done = 1; end
      cyc++;
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0; i_mem_ack = 1'b0; d_mem_ack = 1'b0;
      #1;
      chk("abort_ireq", 32'(i_mem_req), 1);
      chk("abort_instret", 32'(instret), 0);
      chk("abort_rf_we", n_rf, 0);
      chk("abort_pc_we", n_pc, 0);
      model_cnt = 0;
      @(posedge clk); #1;
      return;
    end
    chk("done", 32'(done), 1);
    ls     = (c == C_LD) || (c == C_ST);
    e_dreq = ls ? dw + 1 : 0;
    e_dwe  = (c == C_ST) ? dw + 1 : 0;
    e_rf   = (c == C_ST || c == C_BR || c == C_ILL) ? 0 : 1;
    e_cyc  = (iw + 1) + 2 + e_dreq + ((c == C_BR || c == C_ST) ? 0 : 1);
    chk("i_mem_req_cycles", n_ireq, iw + 1);
    chk("ir_we_count", n_irwe, 1);
    chk("d_mem_req_cycles", n_dreq, e_dreq);
    chk("d_mem_we_cycles", n_dwe, e_dwe);
    chk("d_mem_we_no_req", n_dwe_bad, 0);
    chk("rf_we_count", n_rf, e_rf);
    chk("pc_we_count", n_pc, 1);
    chk("pc_src", 32'(pcs), (c == C_BR) ? 32'(flag) : 32'(c == C_JAL || c == C_JALR));
    if (e_rf != 0) chk("rf_src", 32'(rfs), 32'(c == C_LD));
    if (c != C_ILL) begin
      chk("alu_cmd", 32'(acmd), 32'(exp_alu(c)));
      chk("alu_src", 32'(asrc), 32'(c == C_I || c == C_LD || c == C_ST || c == C_JALR));
    end
    chk("cycles", cyc, e_cyc);
    chk("illegal_cycles", n_ill, 0);
    model_cnt++;
    @(posedge clk); #1;
    chk("instret", 32'(instret), 32'(model_cnt % (1 << CNT_W)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_strobes", strobes(), 0);
    chk("reset_illegal", 32'(illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_instret", 32'(instret), 0);
    chk("reset_ireq", 32'(i_mem_req), 1);
    model_cnt = 0;
    @(posedge clk); #1;
  endtask

`ifdef UC_ILLEGAL_TRAP_EN
  task automatic halt_test();
    int n_ill, n_str;
    n_ill = 0; n_str = 0;
    @(negedge clk);
    opcode = 7'b1111111; i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      i_mem_ack = 1'($urandom); d_mem_ack = 1'($urandom);
      @(negedge clk);
      #1;
      if (illegal) n_ill++;
      n_str += strobes();
    end
    chk("halt_illegal_cycles", n_ill, 8);
    chk("halt_strobes", n_str, 0);
    chk("halt_instret", 32'(instret), 32'(model_cnt % (1 << CNT_W)));
    i_mem_ack = 1'b0; d_mem_ack = 1'b0;
    @(posedge clk); #1;
    do_reset();
  endtask
`endif

  localparam int NOPS = 11;
  logic [6:0] op_tab [NOPS] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000};

  initial begin
    rst = 1'b1; opcode = '0; alu_flags = '0; i_mem_ack = 1'b0; d_mem_ack = 1'b0;
    do_reset();
    run_instr(7'b0110011, 2, 0, 1'b0, 1'b0);   // add, fetch waits 2
    run_instr(7'b0100011, 0, 3, 1'b0, 1'b0);   // store, data waits 3
    run_instr(7'b1100011, 1, 0, 1'b1, 1'b0);   // beq taken
    run_instr(7'b1100011, 0, 0, 1'b0, 1'b0);   // beq not taken
    run_instr(7'b0000011, 1, 2, 1'b0, 1'b0);   // load
    run_instr(7'b1101111, 0, 0, 1'b0, 1'b0);   // jal
    run_instr(7'b1100111, 0, 0, 1'b0, 1'b0);   // jalr
    run_instr(7'b0010111, 0, 0, 1'b0, 1'b0);   // auipc
`ifdef UC_ILLEGAL_TRAP_EN
    halt_test();
`else
    run_instr(7'b1111111, 0, 0, 1'b0, 1'b0);   // unknown executes as NOP
`endif
    run_instr(7'b0000011, 0, 5, 1'b0, 1'b1);   // reset during load MEM wait
    for (int n = 0; n < 40; n++) begin
`ifdef UC_ILLEGAL_TRAP_EN
      run_instr(op_tab[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
`else
      run_instr(op_tab[$urandom_range(0, NOPS-1)], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
